// File: rtl/fifo_rd_burst_pkg.sv
// Shared state type and sizing constants for the fifo_rd_burst read-side framer.
package fifo_rd_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int BUF_DEPTH   = 4;
  localparam int BURST_CNT_W = 16;
  localparam int OCC_W       = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_buf.sv
// Small circular queue that absorbs words arriving one cycle after each FIFO read.
module fifo_rd_buf
  import fifo_rd_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [OCC_W-1:0]      occ
);

  localparam int PTR_W = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_pop;

  assign do_pop = pop && (occ != '0);
  assign head   = mem[rd_ptr];

  // The upstream read issue logic guarantees a push never lands on a full queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_burst.sv
// Pulls words from a standard-mode FIFO and re-emits them as BURST_LEN-beat bursts.
// Define FIFO_RD_BURST_TIMEOUT_EN to close a stalled partial burst after TIMEOUT idle cycles.
module fifo_rd_burst
  import fifo_rd_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  output logic                   fifo_ren,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic [BURST_CNT_W-1:0] burst_cnt
);

  localparam int              BEAT_W    = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t              state;
  state_t              state_nxt;
  logic                rd_pend;
  logic [OCC_W-1:0]    occ;
  logic [BEAT_W-1:0]   beat_cnt;
  logic                hs;
  logic                in_flush;
  logic                timeout_hit;

  fifo_rd_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rd_pend),
    .push_data(fifo_dout),
    .pop      (hs),
    .head     (m_data),
    .occ      (occ)
  );

  assign in_flush = (state == FLUSH);
  assign hs       = m_valid && m_ready;

  // A head word is only shown once we know whether it closes the burst.
  always_comb begin
    fifo_ren = rst_n && !fifo_empty && (state != FLUSH) &&
               ((occ + OCC_W'(rd_pend)) < OCC_W'(BUF_DEPTH));
    m_valid  = (occ != '0) &&
               ((occ >= OCC_W'(2)) || rd_pend || (beat_cnt == LAST_BEAT) || in_flush);
    m_last   = m_valid && ((beat_cnt == LAST_BEAT) || in_flush);
  end

`ifdef FIFO_RD_BURST_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_cond;

  assign idle_cond   = (state == RUN) && (occ == OCC_W'(1)) && !rd_pend &&
                       fifo_empty && !m_valid;
  assign timeout_hit = idle_cond && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (idle_cond && !timeout_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT;

  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (fifo_ren) state_nxt = RUN;
      end
      RUN: begin
        if (timeout_hit) begin
          state_nxt = FLUSH;
        end else if (hs && m_last && (occ == OCC_W'(1)) && !rd_pend && !fifo_ren) begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        if (hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_pend   <= 1'b0;
      beat_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= fifo_ren;
      if (hs) begin
        beat_cnt <= m_last ? '0 : beat_cnt + 1'b1;
        if (m_last) burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_burst.sv
// Scoreboard bench for fifo_rd_burst; expectations adapt to FIFO_RD_BURST_TIMEOUT_EN.
module tb_fifo_rd_burst;

  localparam int DW    = 32;
  localparam int BL    = 16;
  localparam int TO    = 8;
  localparam int DEPTH = 4;
`ifdef FIFO_RD_BURST_TIMEOUT_EN
  localparam bit TIMEOUT_BUILD = 1'b1;
`else
  localparam bit TIMEOUT_BUILD = 1'b0;
`endif

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_ren;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic [15:0]   burst_cnt;

  beat_t         exp_q[$];
  logic [DW-1:0] up_q[$];
  int            compared = 0;
  int            mismatched = 0;
  int            hs_count = 0;
  int            model_beat = 0;
  int            model_bursts = 0;
  int            outstanding = 0;
  int            ready_mode = 0;
  logic          ready_fixed = 1'b0;
  logic          stall = 1'b0;
  bit            stall_mode = 1'b0;
  int            stall_run = 0;
  logic          stalled = 1'b0;
  beat_t         held;

  always #5 clk = ~clk;

  fifo_rd_burst #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_ren  (fifo_ren),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .burst_cnt (burst_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Queue one word upstream; its burst position follows from words issued so far.
  task automatic applyStimulus(input logic [DW-1:0] data, input bit force_last);
    beat_t b;
    b.data = data;
    b.last = force_last || (model_beat == BL - 1);
    model_beat = b.last ? 0 : model_beat + 1;
    up_q.push_back(data);
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain_pending", exp_q.size(), 0);
    tick();
    tick();
  endtask

  // Upstream FIFO model: data returns one cycle after each read strobe.
  initial begin
    fifo_dout  = '0;
    fifo_empty = 1'b1;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        outstanding = 0;
      end else begin
        if (m_valid && m_ready) outstanding--;
        if (fifo_ren) begin
          checkOutput("ren_while_empty", fifo_empty, 0);
          if (!fifo_empty) begin
            fifo_dout <= up_q.pop_front();
            outstanding++;
            checkOutput("occupancy_bound", outstanding > DEPTH, 0);
          end
        end
      end
      #2 fifo_empty = stall || (up_q.size() == 0);
    end
  end

  // Downstream ready and upstream stall pattern generator.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = ($urandom_range(0, 2) != 0);
        default: m_ready = ready_fixed;
      endcase
      if (stall_mode && stall_run < 3 && $urandom_range(0, 3) == 0) begin
        stall = 1'b1;
        stall_run++;
      end else begin
        stall = 1'b0;
        stall_run = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    beat_t want;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checkOutput("stable_valid", m_valid, 1);
          checkOutput("stable_beat", {m_last, m_data}, held);
        end
        if (m_valid && m_ready) begin
          hs_count++;
          checkOutput("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checkOutput("beat_data", m_data, want.data);
            checkOutput("beat_last", m_last, want.last);
            if (want.last) model_bursts++;
          end
          stalled = 1'b0;
        end else begin
          stalled = m_valid;
          held    = {m_last, m_data};
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    int base;
    int n;
    int gap;

    repeat (3) tick();
    checkOutput("reset_outputs", {fifo_ren, m_valid, m_last, m_data, burst_cnt}, 0);
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      tick();
      if (fifo_ren || m_valid || m_last || m_data != '0 || burst_cnt != '0) bad++;
    end
    checkOutput("empty_guard", bad, 0);

    ready_fixed = 1'b1;
    for (int i = 0; i < 32; i++) applyStimulus(DW'(i), 1'b0);
    drain(400);
    checkOutput("burst_cnt_steady", burst_cnt, model_bursts);
    checkOutput("burst_cnt_two", burst_cnt, 2);

    ready_mode = 1;
    for (int i = 0; i < 16; i++) applyStimulus($urandom, 1'b0);
    drain(400);
    ready_mode = 0;
    checkOutput("burst_cnt_backpressure", burst_cnt, model_bursts);

    ready_mode = 2;
    stall_mode = 1'b1;
    for (int i = 0; i < 48; i++) applyStimulus($urandom, 1'b0);
    drain(2000);
    stall_mode = 1'b0;
    ready_mode = 0;
    tick();
    tick();
    checkOutput("burst_cnt_random", burst_cnt, model_bursts);

    base = hs_count;
    for (int i = 0; i < 3; i++) applyStimulus($urandom, (i == 2) && TIMEOUT_BUILD);
    n = 0;
    while (hs_count < base + 2 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("two_beats_before_hold", hs_count - base, 2);
    gap = 0;
    while (!m_valid && gap < 60) begin
      gap++;
      tick();
    end
`ifdef FIFO_RD_BURST_TIMEOUT_EN
    checkOutput("timeout_gap", gap, TO);
    checkOutput("flush_last", m_last, 1);
`else
    checkOutput("held_without_timeout", gap, 60);
`endif
    for (int i = 0; i < (TIMEOUT_BUILD ? 16 : 13); i++) applyStimulus($urandom, 1'b0);
    drain(400);
    checkOutput("burst_cnt_partial", burst_cnt, model_bursts);

    base = hs_count;
    for (int i = 0; i < 32; i++) applyStimulus(DW'(i + 100), 1'b0);
    n = 0;
    while (hs_count < base + 5 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("reach_beat5", hs_count - base, 5);
    rst_n        = 1'b0;
    ready_fixed  = 1'b0;
    up_q.delete();
    exp_q.delete();
    model_beat   = 0;
    model_bursts = 0;
    tick();
    checkOutput("reset_mid_burst", {fifo_ren, m_valid, m_last, m_data, burst_cnt}, 0);
    rst_n       = 1'b1;
    ready_fixed = 1'b1;
    for (int i = 0; i < 16; i++) applyStimulus($urandom, 1'b0);
    drain(400);
    checkOutput("burst_cnt_after_reset", burst_cnt, model_bursts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
